// File: rtl/dma_axi_rd_burst_pkg.sv
// dma_axi_rd_burst_pkg: shared AXI constants, FSM state type and clog2 helper for the read DMA
package dma_axi_rd_burst_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4K_BYTES   = 4096;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEF   = 3'b000;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FIN} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/dma_axi_rd_burst_if.sv
// dma_axi_rd_burst_if: AXI4 read address/data channels plus the outgoing valid/ready stream
interface dma_axi_rd_burst_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              o_ready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output rready, o_valid, o_data, o_last,
        input  arready, rid, rdata, rresp, rlast, rvalid, o_ready
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  rready, o_valid, o_data, o_last,
        output arready, rid, rdata, rresp, rlast, rvalid, o_ready
    );
endinterface

// File: rtl/dma_axi_rd_burst_len.sv
// dma_axi_burst_len: next burst size = min(remaining beats, MAX_BURST, beats left before the 4 KB line)
module dma_axi_burst_len
    import dma_axi_rd_burst_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic [LEN_W-1:0]           rem,
    input  logic [11:0]                addr_lo,
    output logic [clog2(MAX_BURST):0]  burst,
    output logic [7:0]                 arlen
);
    localparam int SH = clog2(DATA_W / 8);
    localparam int CW = clog2(MAX_BURST) + 1;

    logic [12:0]   b4k;
    logic [CW-1:0] cap;

    always_comb begin
        b4k   = (13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> SH;
        cap   = (rem < LEN_W'(MAX_BURST)) ? CW'(rem) : CW'(MAX_BURST);
        burst = (13'(cap) <= b4k) ? cap : CW'(b4k);
        arlen = 8'(burst - 1'b1);
    end
endmodule

// File: rtl/dma_axi_rd_burst.sv
// dma_axi_rd_burst: AXI4 read DMA splitting one transfer into 4 KB-safe INCR bursts onto a stream
module dma_axi_rd_burst
    import dma_axi_rd_burst_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int ID_W      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              error,
    dma_axi_rd_burst_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int CW    = clog2(MAX_BURST) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d, burst;
    logic              error_q, error_d, beat;
    logic [7:0]        arlen;

    dma_axi_burst_len #(.LEN_W(LEN_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) u_len (
        .rem(rem_q), .addr_lo(addr_q[11:0]), .burst(burst), .arlen(arlen)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        beat    = state_q == S_DATA && bus.rvalid && bus.o_ready;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = (len != '0) ? S_ADDR : S_FIN;
                addr_d  = start_addr & ~ADDR_W'(BYTES - 1);
                rem_d   = len;
                error_d = 1'b0;
            end
            S_ADDR: if (bus.arready) begin
                state_d = S_DATA;
                cnt_d   = burst;
            end
            S_DATA: if (beat) begin
                cnt_d  = cnt_q - 1'b1;
                rem_d  = rem_q - 1'b1;
                addr_d = addr_q + ADDR_W'(BYTES);
                // The local beat count, not rlast, decides where the burst ends
                if (bus.rresp != AXI_RESP_OKAY || bus.rlast != (cnt_q == CW'(1))) error_d = 1'b1;
                if (cnt_q == CW'(1)) state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_ADDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = state_q == S_ADDR || state_q == S_DATA;
    assign done        = state_q == S_FIN;
    assign error       = error_q;
    assign bus.arid    = '0;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = arlen;
    assign bus.arsize  = 3'(clog2(BYTES));
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = 1'b0;
    assign bus.arcache = AXI_CACHE_DEF;
    assign bus.arprot  = AXI_PROT_DEF;
    assign bus.arqos   = '0;
    assign bus.arvalid = state_q == S_ADDR;
    assign bus.rready  = state_q == S_DATA && bus.o_ready;
    assign bus.o_valid = state_q == S_DATA && bus.rvalid;
    assign bus.o_data  = bus.rdata;
    assign bus.o_last  = state_q == S_DATA && rem_q == LEN_W'(1);
endmodule

// File: tb/tb_dma_axi_rd_burst.sv
// tb_dma_axi_rd_burst: directed bench for the read DMA with a hand-driven AXI slave and stream sink
module tb_dma_axi_rd_burst;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic [15:0] len;
    logic        busy, done, error;
    int          n_chk = 0;
    int          n_err = 0;
    int          beat;
    int          tot;
    int          cyc;

    dma_axi_rd_burst_if #(.ADDR_W(32), .DATA_W(32), .ID_W(1)) bus ();

    dma_axi_rd_burst #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_BURST(16), .ID_W(1)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
        .busy(busy), .done(done), .error(error), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] l);
        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ar_accept(input logic [31:0] a, input logic [7:0] l);
        for (int i = 0; i < 20 && bus.arvalid !== 1'b1; i++) @(negedge clk);
        chk("arvalid", bus.arvalid, 1);
        chk("araddr", bus.araddr, a);
        chk("arlen", bus.arlen, l);
        chk("arsize", bus.arsize, 2);
        chk("arburst", bus.arburst, 1);
        chk("arcache", bus.arcache, 4'b0011);
        @(negedge clk);
        chk("arvalid_hold", bus.arvalid, 1);
        chk("araddr_hold", bus.araddr, a);
        chk("arlen_hold", bus.arlen, l);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
    endtask

    task automatic r_burst(input int n, input int err_idx, input int last_idx);
        for (int i = 0; i < n; i++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hA000_0000 + beat;
            bus.rresp  = (i == err_idx) ? 2'b10 : 2'b00;
            bus.rlast  = (i == last_idx);
            #1;
            chk("o_valid", bus.o_valid, 1);
            chk("o_data", bus.o_data, 32'hA000_0000 + beat);
            chk("o_last", bus.o_last, beat == tot - 1);
            chk("rready", bus.rready, 1);
            @(negedge clk);
            beat++;
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
    endtask

    task automatic wait_done(input logic exp_err);
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        chk("done", done, 1);
        chk("busy_at_done", busy, 0);
        chk("error_at_done", error, exp_err);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        start_addr = '0;
        len = '0;
        bus.arready = 1'b0;
        bus.rid = '0;
        bus.rdata = '0;
        bus.rresp = 2'b00;
        bus.rlast = 1'b0;
        bus.rvalid = 1'b0;
        bus.o_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_static", {bus.arlock, bus.arprot, bus.arqos}, 0);
        rst = 1'b1;
        @(negedge clk);

        // three bursts, 16+16+8 beats
        tot = 40; beat = 0;
        do_start(32'h1000, 16'd40);
        chk("busy_t1", busy, 1);
        ar_accept(32'h1000, 8'd15);
        r_burst(16, -1, 15);
        ar_accept(32'h1040, 8'd15);
        r_burst(16, -1, 15);
        ar_accept(32'h1080, 8'd7);
        r_burst(8, -1, 7);
        wait_done(1'b0);

        // split at the 4 KB line
        tot = 16; beat = 0;
        do_start(32'h0FF0, 16'd16);
        ar_accept(32'h0FF0, 8'd3);
        r_burst(4, -1, 3);
        ar_accept(32'h1000, 8'd11);
        r_burst(12, -1, 11);
        wait_done(1'b0);

        // SLVERR on beat 5 of 8
        tot = 8; beat = 0;
        do_start(32'h2000, 16'd8);
        ar_accept(32'h2000, 8'd7);
        r_burst(8, 4, 7);
        wait_done(1'b1);
        chk("error_sticky", error, 1);

        // stream back-pressure toggling every cycle
        tot = 4; beat = 0; cyc = 0;
        do_start(32'h3000, 16'd4);
        chk("error_cleared", error, 0);
        ar_accept(32'h3000, 8'd3);
        while (beat < 4 && cyc < 20) begin
            bus.o_ready = (cyc % 2 == 0);
            bus.rvalid  = 1'b1;
            bus.rdata   = 32'hA000_0000 + beat;
            bus.rlast   = (beat == 3);
            #1;
            chk("rready_mirror", bus.rready, bus.o_ready);
            chk("o_data_bp", bus.o_data, 32'hA000_0000 + beat);
            chk("busy_bp", busy, 1);
            @(negedge clk);
            if (bus.o_ready) beat++;
            cyc++;
        end
        bus.o_ready = 1'b1;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        wait_done(1'b0);

        // zero-length start
        do_start(32'h6000, 16'd0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_arvalid", bus.arvalid, 0);
        @(negedge clk);
        chk("len0_done_pulse", done, 0);
        chk("len0_arvalid2", bus.arvalid, 0);

        // start while busy is ignored
        tot = 2; beat = 0;
        do_start(32'h4000, 16'd2);
        ar_accept(32'h4000, 8'd1);
        do_start(32'h9000, 16'd5);
        chk("busy_ignore", busy, 1);
        r_burst(2, -1, 1);
        wait_done(1'b0);
        chk("ignore_arvalid", bus.arvalid, 0);
        chk("ignore_busy", busy, 0);

        // early rlast on beat 3 of 4
        tot = 4; beat = 0;
        do_start(32'h5000, 16'd4);
        ar_accept(32'h5000, 8'd3);
        r_burst(4, -1, 2);
        wait_done(1'b1);
        chk("rlast_idle_busy", busy, 0);

        // asynchronous reset in DATA
        tot = 4; beat = 0;
        do_start(32'h7000, 16'd4);
        ar_accept(32'h7000, 8'd3);
        r_burst(1, -1, 3);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_arvalid", bus.arvalid, 0);
        chk("arst_araddr", bus.araddr, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_arvalid", bus.arvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
